// File: rtl/fx3_transfer.sv
// fx3_transfer: read-side drain stage between the ping-pong sample buffer and
// the FX3 GPIF slave interface. Once a full buffer half is available and the
// FX3 reports DMA space, it reads exactly one burst of BURST_LEN 10-bit
// samples. It forwards them zero-extended to 16 bits with an active-low write
// strobe, counts completed bursts and flags FX3 handshake violations.
//
// Ports:
//   clock, reset   - FX3/read clock; synchronous active-high reset
//   collectData    - capture enable (level)
//   testMode       - substitute a 10-bit incrementing pattern for buffer data
//   dataAvailable  - buffer read side holds a full half
//   bufferData     - buffer output, valid one cycle after isReading
//   fx3Ready       - FX3 DMA flag (space for BURST_LEN words)
//   isReading      - buffer read request
//   fx3Data        - FX3 data bus {6'b0, sample}
//   fx3nWrite      - FX3 write strobe, active low
//   busy           - high whenever not idle
//   transferError  - sticky: fx3Ready dropped during an active burst
//   burstCount     - completed bursts, wraps at 16 bits
module fx3_transfer #(
  parameter int unsigned BURST_LEN = 8192,
  parameter int unsigned CNT_W     = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        collectData,
  input  logic        testMode,
  input  logic        dataAvailable,
  input  logic [9:0]  bufferData,
  input  logic        fx3Ready,
  output logic        isReading,
  output logic [15:0] fx3Data,
  output logic        fx3nWrite,
  output logic        busy,
  output logic        transferError,
  output logic [15:0] burstCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              drain_q, drain_d;
  logic              rd_q, rd_d;
  logic              rv_q, rv_d;
  logic              nwr_q, nwr_d;
  logic [15:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic [9:0]        pat_q, pat_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    rd_d    = rd_q;
    bcnt_d  = bcnt_q;
    cnt_inc = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = 1'b0;
        if (collectData && dataAvailable && fx3Ready) begin
          state_d = READ;
          rd_d    = 1'b1;
        end
      end
      READ: begin
        // The terminal count is reached on the last read cycle, so the
        // request is dropped exactly after BURST_LEN asserted cycles.
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          rd_d    = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      DONE: begin
        // Wait for the stale full-half flag to clear before rearming.
        if (!dataAvailable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // Two-stage output pipeline: read-valid flag, then data + strobe.
    rv_d   = rd_q;
    nwr_d  = ~rv_q;
    data_d = data_q;
    pat_d  = pat_q;
    if (rv_q) begin
      if (testMode) begin
        data_d = {6'b0, pat_q};
        pat_d  = pat_q + 1'b1;
      end else begin
        data_d = {6'b0, bufferData};
      end
    end

    // Clear first so a simultaneous set takes priority.
    err_d = err_q;
    if ((state_q == IDLE) && !collectData) err_d = 1'b0;
    if (!fx3Ready && (rd_q || !nwr_q))     err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      rd_q    <= 1'b0;
      rv_q    <= 1'b0;
      nwr_q   <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      nwr_q   <= nwr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      pat_q   <= pat_d;
    end
  end

  assign isReading     = rd_q;
  assign fx3Data       = data_q;
  assign fx3nWrite     = nwr_q;
  assign busy          = busy_q;
  assign transferError = err_q;
  assign burstCount    = bcnt_q;

endmodule

// File: tb/tb_fx3_transfer.sv
// Bench for fx3_transfer with BURST_LEN=16. A timeline model tracks each burst
// by the number of edges since its start edge; a negedge process compares all
// outputs every cycle, and directed sections pin the model with literals.
module tb_fx3_transfer;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        reset, collectData, testMode, dataAvailable, fx3Ready;
  logic [9:0]  bufferData;
  logic        isReading, fx3nWrite, busy, transferError;
  logic [15:0] fx3Data, burstCount;

  fx3_transfer #(.BURST_LEN(L), .CNT_W(5)) dut (
    .clock(clk), .reset(reset), .collectData(collectData), .testMode(testMode),
    .dataAvailable(dataAvailable), .bufferData(bufferData), .fx3Ready(fx3Ready),
    .isReading(isReading), .fx3Data(fx3Data), .fx3nWrite(fx3nWrite),
    .busy(busy), .transferError(transferError), .burstCount(burstCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          chk_en = 1'b0;
  bit          m_idle = 1'b1;
  int          rel = 0;           // edges since the burst start edge
  bit          e_rd = 1'b0, e_wr = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [15:0] e_data = '0, e_bcnt = '0;
  int          pat = 0;
  bit          ram_fire = 1'b0;   // buffer sampled a read request at this edge
  logic [9:0]  bq[$];             // samples handed out by the buffer, in order
  bit          use_index = 1'b0;

  task automatic model_edge();
    bit p_idle, p_rd, p_wr;
    logic [9:0] bv;
    if (reset) begin
      m_idle = 1'b1; rel = 0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
      e_err = 1'b0; e_data = '0; e_bcnt = '0; pat = 0; ram_fire = 1'b0;
      bq.delete();
      chk_en = 1'b1;
    end else begin
      p_idle = m_idle; p_rd = e_rd; p_wr = e_wr;
      ram_fire = e_rd;
      if (m_idle) begin
        if (collectData && dataAvailable && fx3Ready) begin
          m_idle = 1'b0;
          rel = 0;
        end
      end else begin
        rel++;
        if (rel >= L + 3 && !dataAvailable) m_idle = 1'b1;
      end
      e_rd   = !m_idle && (rel < L);
      e_wr   = !m_idle && (rel >= 2) && (rel <= L + 1);
      e_busy = !m_idle;
      if (!m_idle && rel == L + 2) e_bcnt = e_bcnt + 16'd1;
      if (e_wr) begin
        bv = '0;
        if (bq.size() > 0) bv = bq.pop_front();
        if (testMode) begin
          e_data = 16'(pat);
          pat = (pat + 1) % 1024;
        end else begin
          e_data = {6'b0, bv};
        end
      end
      if (p_idle && !collectData) e_err = 1'b0;
      if (!fx3Ready && (p_rd || p_wr)) e_err = 1'b1;
    end
  endtask

  // Advance one clock: update the model from the inputs at the edge, then
  // emulate the buffer RAM answering a sampled read request.
  task automatic step(input int n);
    logic [9:0] v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (ram_fire) begin
        v = use_index ? 10'(rel - 1) : 10'($urandom);
        bq.push_back(v);
        bufferData = v;
      end else begin
        bufferData = 10'($urandom);
      end
    end
  endtask

  // ---------------- compare process ----------------
  int          wr_total = 0;
  int          rd_total = 0;
  logic [15:0] wlog[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("isReading", {31'b0, isReading}, {31'b0, e_rd});
        chk("fx3nWrite", {31'b0, fx3nWrite}, {31'b0, !e_wr});
        chk("fx3Data", {16'b0, fx3Data}, {16'b0, e_data});
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("transferError", {31'b0, transferError}, {31'b0, e_err});
        chk("burstCount", {16'b0, burstCount}, {16'b0, e_bcnt});
        if (!fx3nWrite) begin
          wr_total++;
          wlog.push_back(fx3Data);
        end
        if (isReading) rd_total++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int w0, r0, n0;

  initial begin
    reset = 1'b1; collectData = 1'b0; testMode = 1'b0; dataAvailable = 1'b0;
    fx3Ready = 1'b0; bufferData = '0;
    step(3);
    reset = 1'b0;
    chk("rst_burstCount", {16'b0, burstCount}, 32'd0);
    chk("rst_fx3nWrite", {31'b0, fx3nWrite}, 32'd1);
    chk("rst_fx3Data", {16'b0, fx3Data}, 32'd0);
    step(2);

    // Single burst with bufferData = read index
    use_index = 1'b1;
    collectData = 1'b1; fx3Ready = 1'b1; dataAvailable = 1'b1;
    w0 = wr_total; r0 = rd_total; n0 = wlog.size();
    step(1);
    dataAvailable = 1'b0;
    step(30);
    chk("single_writes", 32'(wr_total - w0), 32'd16);
    chk("single_reads", 32'(rd_total - r0), 32'd16);
    chk("single_bursts", {16'b0, burstCount}, 32'd1);
    if (wlog.size() >= n0 + 16) begin
      chk("single_first", {16'b0, wlog[n0]}, 32'h0000);
      chk("single_last", {16'b0, wlog[n0 + 15]}, 32'h000F);
    end else begin
      chk("single_logsize", 32'(wlog.size() - n0), 32'd16);
    end
    use_index = 1'b0;

    // Stale flag held high after the burst
    dataAvailable = 1'b1; r0 = rd_total;
    step(1);
    step(29);
    chk("stale_busy_held", {31'b0, busy}, 32'd1);
    dataAvailable = 1'b0;
    step(1);
    chk("stale_idle_next", {31'b0, busy}, 32'd0);
    chk("stale_reads", 32'(rd_total - r0), 32'd16);
    chk("stale_bursts", {16'b0, burstCount}, 32'd2);
    step(3);

    // FX3 stall then fx3Ready drop mid-burst
    fx3Ready = 1'b0; dataAvailable = 1'b1; w0 = wr_total; r0 = rd_total;
    step(5);
    chk("stall_noreads", 32'(rd_total - r0), 32'd0);
    chk("stall_busy", {31'b0, busy}, 32'd0);
    fx3Ready = 1'b1;
    step(1);
    dataAvailable = 1'b0;
    step(4);
    fx3Ready = 1'b0;
    step(1);
    fx3Ready = 1'b1;
    step(25);
    chk("stall_err", {31'b0, transferError}, 32'd1);
    chk("stall_writes", 32'(wr_total - w0), 32'd16);
    chk("stall_bursts", {16'b0, burstCount}, 32'd3);
    collectData = 1'b0;
    step(1);
    chk("stall_err_clr", {31'b0, transferError}, 32'd0);

    // collectData drops mid-burst
    collectData = 1'b1; dataAvailable = 1'b1; w0 = wr_total;
    step(1);
    dataAvailable = 1'b0;
    step(3);
    collectData = 1'b0;
    step(25);
    dataAvailable = 1'b1;
    step(5);
    chk("drop_idle", {31'b0, busy}, 32'd0);
    chk("drop_writes", 32'(wr_total - w0), 32'd16);
    chk("drop_bursts", {16'b0, burstCount}, 32'd4);
    dataAvailable = 1'b0;
    step(2);

    // testMode: 70 bursts, pattern wraps after 1023
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    testMode = 1'b1; collectData = 1'b1; fx3Ready = 1'b1;
    w0 = wr_total; n0 = wlog.size();
    for (int b = 0; b < 70; b++) begin
      dataAvailable = 1'b1;
      step(1);
      dataAvailable = 1'b0;
      step(20);
    end
    chk("tm_writes", 32'(wr_total - w0), 32'd1120);
    chk("tm_bursts", {16'b0, burstCount}, 32'd70);
    if (wlog.size() >= n0 + 1120) begin
      chk("tm_word0", {16'b0, wlog[n0]}, 32'h0000);
      chk("tm_word1023", {16'b0, wlog[n0 + 1023]}, 32'h03FF);
      chk("tm_word1024", {16'b0, wlog[n0 + 1024]}, 32'h0000);
      chk("tm_word1119", {16'b0, wlog[n0 + 1119]}, 32'h005F);
    end else begin
      chk("tm_logsize", 32'(wlog.size() - n0), 32'd1120);
    end
    testMode = 1'b0;

    // Reset mid-burst
    dataAvailable = 1'b1;
    step(1);
    dataAvailable = 1'b0;
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_isReading", {31'b0, isReading}, 32'd0);
    chk("midrst_fx3nWrite", {31'b0, fx3nWrite}, 32'd1);
    chk("midrst_bursts", {16'b0, burstCount}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    w0 = wr_total;
    dataAvailable = 1'b1;
    step(1);
    dataAvailable = 1'b0;
    step(25);
    chk("midrst_writes", 32'(wr_total - w0), 32'd16);
    chk("midrst_bursts2", {16'b0, burstCount}, 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 299) == 0);
      collectData   = ($urandom_range(0, 7) != 0);
      dataAvailable = ($urandom_range(0, 2) != 0);
      fx3Ready      = ($urandom_range(0, 9) != 0);
      testMode      = ($urandom_range(0, 63) < 16) ? ~testMode : testMode;
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
